// File: rtl/serial_add_pkg.sv
// Shared types and limits for the bit-serial adder controller.
package serial_add_pkg;

    localparam int WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// Team 1-bit full adder cell, time-shared by the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder, one operand bit per clock, LSB first,
// sequenced by a start/busy/done handshake.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("serial_add_ctrl: WIDTH out of range 1..%0d", WIDTH_MAX);
    end

    state_e             state_q;
    logic [WIDTH-1:0]   a_sh_q, b_sh_q, r_sh_q, sum_q;
    logic               c_q, cout_q, busy_q, done_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               fa_sum, fa_carry, last_bit;
    logic [WIDTH-1:0]   r_sh_d;

    full_adder u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .cin   (c_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Result bits enter at the MSB so the first (LSB) sum bit ends up at bit 0.
    if (WIDTH == 1) begin : g_r_one
        assign r_sh_d = fa_sum;
    end else begin : g_r_many
        assign r_sh_d = {fa_sum, r_sh_q[WIDTH-1:1]};
    end

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // NOTE: every register here uses <= so all of them see pre-edge values;
    // blocking assignments would let the shifts read already-updated state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_q  <= op_a;
                        b_sh_q  <= op_b;
                        c_q     <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sh_q <= r_sh_d;
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    c_q    <= fa_carry;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        sum_q   <= r_sh_d;
                        cout_q  <= fa_carry;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=1, 8 and 32 against an
// arithmetic reference model.
module tb_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start8, start32;
    logic [31:0] op_a, op_b;
    logic        cin;

    logic        busy1, done1, cout1;
    logic [0:0]  sum1;
    logic        busy8, done8, cout8;
    logic [7:0]  sum8;
    logic        busy32, done32, cout32;
    logic [31:0] sum32;

    int n_checks = 0;
    int n_pass   = 0;
    int viol     = 0;
    int sel_w    = 8;

    logic        mbusy, mdone;
    logic [63:0] mres;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op_a(op_a[0:0]), .op_b(op_b[0:0]),
        .cin(cin), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op_a(op_a[7:0]), .op_b(op_b[7:0]),
        .cin(cin), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));

    serial_add_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .op_a(op_a), .op_b(op_b),
        .cin(cin), .busy(busy32), .done(done32), .sum(sum32), .cout(cout32));

    always_comb begin
        mbusy = busy8;
        mdone = done8;
        mres  = {55'd0, cout8, sum8};
        case (sel_w)
            1: begin
                mbusy = busy1;
                mdone = done1;
                mres  = {62'd0, cout1, sum1};
            end
            32: begin
                mbusy = busy32;
                mdone = done32;
                mres  = {31'd0, cout32, sum32};
            end
            default: ;
        endcase
    end

    always @(negedge clk) begin
        if ((busy1 && done1) || (busy8 && done8) || (busy32 && done32))
            viol++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        else
            n_pass++;
    endtask

    // {cout,sum} = a + b + cin over w-bit operands, kept to w+1 bits.
    function automatic logic [63:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return ((64'(a) & m) + (64'(b) & m) + 64'(c)) & ((64'd1 << (w + 1)) - 64'd1);
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            1:       start1  = v;
            32:      start32 = v;
            default: start8  = v;
        endcase
    endtask

    // Called at a negedge with the selected DUT idle; returns at the negedge
    // from which the next start would be accepted.
    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic c, output logic [63:0] res, output int lat,
                          output int busy_n);
        sel_w = w;
        op_a = a;
        op_b = b;
        cin  = c;
        set_start(w, 1'b1);
        @(posedge clk);
        #1;
        set_start(w, 1'b0);
        lat = 0;
        busy_n = 0;
        res = '0;
        for (int k = 1; k <= w + 20; k++) begin
            @(negedge clk);
            if (mbusy) busy_n++;
            if (mdone) begin
                lat = k;
                res = mres;
                break;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] res, prev, exp;
        int          lat, busy_n, hold_err, cnt, last_t, idx;
        logic [31:0] a5 [3];
        logic [31:0] b5 [3];
        logic        c5 [3];
        logic [31:0] ra, rb;
        logic        rc;

        rst = 1'b1;
        start1 = 1'b0; start8 = 1'b0; start32 = 1'b0;
        op_a = '0; op_b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(busy8), 64'd0);
        check("reset_done", 64'(done8), 64'd0);
        check("reset_sum_cout", {55'd0, cout8, sum8}, 64'd0);
        check("reset_w32_sum", {31'd0, cout32, sum32}, 64'd0);
        rst = 1'b0;

        // Basic add with latency and busy length.
        run_op(8, 32'h0F, 32'h01, 1'b0, res, lat, busy_n);
        check("t1_busy_cycles", 64'(busy_n), 64'd8);
        check("t1_done_latency", 64'(lat), 64'd9);
        check("t1_result", res, 64'h010);

        run_op(8, 32'hFF, 32'h01, 1'b0, res, lat, busy_n);
        check("t2_carry_out", res, 64'h100);
        run_op(8, 32'hFF, 32'hFF, 1'b1, res, lat, busy_n);
        check("t2_all_ones", res, 64'h1FF);
        prev = model(8, 32'hFF, 32'hFF, 1'b1);

        // Second start during RUN is ignored; operands may change after capture.
        op_a = 32'h12; op_b = 32'h34; cin = 1'b0;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        hold_err = 0;
        res = '0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 2) begin
                start8 = 1'b1;
                op_a = 32'hAA;
                op_b = 32'h55;
                cin = 1'b1;
            end
            if (k == 3) start8 = 1'b0;
            if (busy8 && ({55'd0, cout8, sum8} !== prev)) hold_err++;
            if (done8) begin
                res = {55'd0, cout8, sum8};
                lat = k;
                break;
            end
        end
        check("t3_result", res, 64'h046);
        check("t3_latency", 64'(lat), 64'd9);
        check("t3_sum_held_in_run", 64'(hold_err), 64'd0);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (busy8 || done8) cnt++;
        end
        check("t3_start_not_queued", 64'(cnt), 64'd0);

        // Reset in the 4th RUN cycle aborts without a done pulse.
        op_a = 32'h77; op_b = 32'h11; cin = 1'b0;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        for (int k = 1; k <= 4; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t4_busy_after_rst", 64'(busy8), 64'd0);
        check("t4_result_after_rst", {55'd0, cout8, sum8}, 64'd0);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done8 || busy8) cnt++;
        end
        check("t4_no_done_after_abort", 64'(cnt), 64'd0);
        run_op(8, 32'h05, 32'h03, 1'b0, res, lat, busy_n);
        check("t4_restart_result", res, 64'h008);

        // start held high: back-to-back operations every WIDTH+2 cycles.
        a5[0] = 32'h21; b5[0] = 32'h43; c5[0] = 1'b0;
        a5[1] = 32'h80; b5[1] = 32'h80; c5[1] = 1'b0;
        a5[2] = 32'h7F; b5[2] = 32'h00; c5[2] = 1'b1;
        sel_w = 8;
        idx = 0;
        last_t = -1;
        op_a = a5[0]; op_b = b5[0]; cin = c5[0];
        start8 = 1'b1;
        for (int t = 0; t < 60 && idx < 3; t++) begin
            @(negedge clk);
            if (done8) begin
                check($sformatf("t5_result_%0d", idx), {55'd0, cout8, sum8},
                      model(8, a5[idx], b5[idx], c5[idx]));
                if (idx > 0) check($sformatf("t5_spacing_%0d", idx), 64'(t - last_t), 64'd10);
                last_t = t;
                idx++;
                if (idx < 3) begin
                    op_a = a5[idx]; op_b = b5[idx]; cin = c5[idx];
                end else begin
                    start8 = 1'b0;
                end
            end
        end
        start8 = 1'b0;
        check("t5_done_count", 64'(idx), 64'd3);
        repeat (3) @(negedge clk);

        // Randomised operations at each width.
        foreach (a5[i]) begin
            int w;
            w = (i == 0) ? 1 : (i == 1) ? 8 : 32;
            for (int n = 0; n < 1000; n++) begin
                ra = $urandom;
                rb = $urandom;
                rc = 1'($urandom_range(0, 1));
                run_op(w, ra, rb, rc, res, lat, busy_n);
                exp = model(w, ra, rb, rc);
                check($sformatf("rand_w%0d_result_%0d", w, n), res, exp);
                check($sformatf("rand_w%0d_latency_%0d", w, n), 64'(lat), 64'(w + 1));
            end
        end

        check("no_busy_done_overlap", 64'(viol), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
